decrypt_mem_writer: RTL and testbench

// - Write-side memory interface: the write counterpart of the encrypted-ROM read interface.
// - Accepts one {address, data} write request from the decrypt FSM under start/finish handshake.
// - Drives the decrypted-message RAM write port.
// - Flags whether each byte is a legal plaintext char (used by key-search early abort).

---
 rtl/decrypt_mem_writer_if.sv | 34 +++
 rtl/decrypt_mem_writer.sv | 112 +++++++++++
 tb/tb_decrypt_mem_writer.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/decrypt_mem_writer_if.sv
// Purpose: groups the decrypt-FSM request handshake and the message-RAM write port.
// Latency: none (wires only); timing is set by decrypt_mem_writer.
// Backpressure: none; the FSM waits for the finish pulse before its next request.
interface decrypt_mem_writer_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
);
  logic              start;
  logic              finish;
  logic [ADDR_W-1:0] FSM_Adr;
  logic [DATA_W-1:0] FSM_Data;
  logic [ADDR_W-1:0] Decrypt_Adr;
  logic [DATA_W-1:0] Decrypt_Data;
  logic              Decrypt_WrEn;
  logic [DATA_W-1:0] DataIn_from_Decrypt;
  logic              Char_Valid;
  logic [CNT_W-1:0]  Write_Count;
  logic              Verify_Err;

  // Requester side: decrypt FSM plus the RAM read-data return path.
  modport master (
    output start, FSM_Adr, FSM_Data, DataIn_from_Decrypt,
    input  finish, Decrypt_Adr, Decrypt_Data, Decrypt_WrEn,
           Char_Valid, Write_Count, Verify_Err
  );

  // Writer side: the decrypt_mem_writer block.
  modport slave (
    input  start, FSM_Adr, FSM_Data, DataIn_from_Decrypt,
    output finish, Decrypt_Adr, Decrypt_Data, Decrypt_WrEn,
           Char_Valid, Write_Count, Verify_Err
  );
endinterface

// File: rtl/decrypt_mem_writer.sv
// Purpose: latch one {address, data} request and issue a single RAM write; flag plaintext chars.
// Latency: start-sampling edge to finish = 3 cycles (5 with WRITE_VERIFY_EN read-back check).
// Backpressure: start is only sampled in IDLE; requests arriving mid-transaction are ignored.
module decrypt_mem_writer #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input logic           clk,
  input logic           reset,
  decrypt_mem_writer_if.slave bus
);

  // Bit 4 is the RAM write enable and bit 3 is finish, so both outputs are
  // plain register bits and cannot glitch. Low bits only keep codes unique.
  typedef enum logic [4:0] {
    IDLE    = 5'b00000,
    LATCH   = 5'b00001,
    WRITE   = 5'b10010,
    HOLD    = 5'b00011,
    RB_WAIT = 5'b00100,
    RB_CHK  = 5'b00101,
    DONE    = 5'b01110
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] adr_q;
  logic [DATA_W-1:0] data_q;
  logic              char_valid_q;
  logic [CNT_W-1:0]  write_count_q;

  // Lower-case letters and space count as legal plaintext.
  function automatic logic char_ok(input logic [DATA_W-1:0] d);
    return ((d >= DATA_W'(8'h61)) && (d <= DATA_W'(8'h7A))) || (d == DATA_W'(8'h20));
  endfunction

  // State register; reset aborts any transaction immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode: fixed sequence, only IDLE waits on an input.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = bus.start ? LATCH : IDLE;
      LATCH:   state_nxt = WRITE;
      WRITE:   state_nxt = HOLD;
`ifdef WRITE_VERIFY_EN
      HOLD:    state_nxt = RB_WAIT;
      RB_WAIT: state_nxt = RB_CHK;
      RB_CHK:  state_nxt = DONE;
`else
      HOLD:    state_nxt = DONE;
`endif
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the request in LATCH and count the write in WRITE; values persist while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      adr_q         <= '0;
      data_q        <= '0;
      char_valid_q  <= 1'b0;
      write_count_q <= '0;
    end else begin
      if (state == LATCH) begin
        adr_q        <= bus.FSM_Adr;
        data_q       <= bus.FSM_Data;
        char_valid_q <= char_ok(bus.FSM_Data);
      end
      if (state == WRITE) begin
        write_count_q <= write_count_q + CNT_W'(1);
      end
    end
  end

`ifdef WRITE_VERIFY_EN
  logic verify_err_q;

  // Sticky read-back mismatch: RAM q is registered, so compare one cycle after HOLD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      verify_err_q <= 1'b0;
    end else if ((state == RB_CHK) && (bus.DataIn_from_Decrypt != data_q)) begin
      verify_err_q <= 1'b1;
    end
  end

  assign bus.Verify_Err = verify_err_q;
`else
  logic unused_rb_dat;

  assign unused_rb_dat  = ^bus.DataIn_from_Decrypt;
  assign bus.Verify_Err = 1'b0;
`endif

  assign bus.Decrypt_WrEn = state[4];
  assign bus.finish       = state[3];
  assign bus.Decrypt_Adr  = adr_q;
  assign bus.Decrypt_Data = data_q;
  assign bus.Char_Valid   = char_valid_q;
  assign bus.Write_Count  = write_count_q;

endmodule

// File: tb/tb_decrypt_mem_writer.sv
// Purpose: scoreboard bench for decrypt_mem_writer with a RAM model and transaction-level reference.
// Latency: expects finish 3 cycles after the start-sampling edge (5 with WRITE_VERIFY_EN).
// Backpressure: start held high must yield one transaction per IDLE visit.
module tb_decrypt_mem_writer;

`ifdef WRITE_VERIFY_EN
  localparam int LAT = 5;
  localparam bit VERIFY = 1'b1;
`else
  localparam int LAT = 3;
  localparam bit VERIFY = 1'b0;
`endif
  localparam int PERIOD = LAT + 2;

  typedef struct {
    int         cyc;
    logic [7:0] adr;
    logic [7:0] data;
    logic       cv;
    logic [7:0] cnt;
    logic       verr;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  bit   corrupt = 1'b0;

  exp_t       wr_q[$];
  exp_t       fin_q[$];
  logic [7:0] dir_adr_q[$];
  logic [7:0] dir_dat_q[$];
  logic [7:0] held_adr = 8'h00;
  logic [7:0] held_dat = 8'h00;
  int         model_cnt = 0;
  logic       model_verr = 1'b0;
  logic [7:0] mem [256];
  logic [7:0] ram_q = 8'h00;

  decrypt_mem_writer_if #(.ADDR_W(8), .DATA_W(8), .CNT_W(8)) bus ();

  decrypt_mem_writer #(.ADDR_W(8), .DATA_W(8), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read RAM; optional single-bit corruption on the read path.
  always @(posedge clk) begin
    if (bus.Decrypt_WrEn) mem[bus.Decrypt_Adr] <= bus.Decrypt_Data;
    ram_q <= mem[bus.Decrypt_Adr];
  end
  assign bus.DataIn_from_Decrypt = ram_q ^ {7'b0, corrupt};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic miss(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=absent required=present (cycle %0d)", name, cyc);
  endtask

  function automatic logic ref_char(input logic [7:0] d);
    return (d == 8'h20) || (d inside {[8'h61:8'h7A]});
  endfunction

  // Monitor: compare every write pulse and finish pulse with the scoreboard heads.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && mon_en) begin
      if (wr_q.size() > 0 && wr_q[0].cyc < cyc) begin
        miss("wren_pulse");
        void'(wr_q.pop_front());
      end
      if (fin_q.size() > 0 && fin_q[0].cyc < cyc) begin
        miss("finish_pulse");
        void'(fin_q.pop_front());
      end
      if (bus.Decrypt_WrEn) begin
        if (wr_q.size() == 0) begin
          chk("wren_unexpected", 32'(bus.Decrypt_WrEn), 32'd0);
        end else begin
          e = wr_q.pop_front();
          chk("wren_cycle", cyc, e.cyc);
          chk("wren_adr", 32'(bus.Decrypt_Adr), 32'(e.adr));
          chk("wren_data", 32'(bus.Decrypt_Data), 32'(e.data));
          held_adr = e.adr;
          held_dat = e.data;
        end
      end else begin
        chk("held_adr", 32'(bus.Decrypt_Adr), 32'(held_adr));
        chk("held_data", 32'(bus.Decrypt_Data), 32'(held_dat));
      end
      if (bus.finish) begin
        if (fin_q.size() == 0) begin
          chk("finish_unexpected", 32'(bus.finish), 32'd0);
        end else begin
          e = fin_q.pop_front();
          chk("finish_cycle", cyc, e.cyc);
          chk("char_valid", 32'(bus.Char_Valid), 32'(e.cv));
          chk("write_count", 32'(bus.Write_Count), 32'(e.cnt));
          chk("verify_err", 32'(bus.Verify_Err), 32'(e.verr));
        end
      end
    end
  end

  task automatic pick(output logic [7:0] a, output logic [7:0] d);
    logic [7:0] tbl [8];
    tbl = '{8'h60, 8'h61, 8'h7A, 8'h7B, 8'h20, 8'h41, 8'h1F, 8'h21};
    if (dir_adr_q.size() > 0) begin
      a = dir_adr_q.pop_front();
      d = dir_dat_q.pop_front();
    end else begin
      a = 8'($urandom);
      d = ($urandom_range(0, 1) == 0) ? tbl[$urandom_range(0, 7)] : 8'($urandom);
    end
  endtask

  // Hold start for n transactions; request data is valid only on the edge leaving LATCH.
  task automatic burst(input int n, input bit with_fin);
    int s;
    logic [7:0] a, d;
    exp_t e;
    @(negedge clk);
    bus.start = 1'b1;
    s = cyc + 1;
    for (int k = 0; k < n; k++) begin
      while (cyc != s) begin
        @(negedge clk);
        if (cyc != s) begin
          bus.FSM_Adr  = 8'($urandom);
          bus.FSM_Data = 8'($urandom);
        end
      end
      pick(a, d);
      bus.FSM_Adr  = a;
      bus.FSM_Data = d;
      model_cnt  = (model_cnt + 1) % 256;
      model_verr = model_verr | (VERIFY & corrupt);
      e.cyc = s + 1; e.adr = a; e.data = d;
      e.cv = ref_char(d); e.cnt = 8'(model_cnt); e.verr = model_verr;
      wr_q.push_back(e);
      e.cyc = s + LAT;
      if (with_fin) fin_q.push_back(e);
      if (k == n - 1) bus.start = 1'b0;
      s = s + PERIOD;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (wr_q.size() > 0 || fin_q.size() > 0); i++) begin
      @(negedge clk);
      bus.FSM_Adr  = 8'($urandom);
      bus.FSM_Data = 8'($urandom);
    end
    repeat ($urandom_range(1, 3)) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wren"}, 32'(bus.Decrypt_WrEn), 32'd0);
    chk({tag, "_finish"}, 32'(bus.finish), 32'd0);
    chk({tag, "_adr"}, 32'(bus.Decrypt_Adr), 32'd0);
    chk({tag, "_data"}, 32'(bus.Decrypt_Data), 32'd0);
    chk({tag, "_char_valid"}, 32'(bus.Char_Valid), 32'd0);
    chk({tag, "_count"}, 32'(bus.Write_Count), 32'd0);
    chk({tag, "_verify_err"}, 32'(bus.Verify_Err), 32'd0);
  endtask

  initial begin
    exp_t e;
    logic [7:0] bnd [6];
    bnd = '{8'h41, 8'h20, 8'h60, 8'h7B, 8'h61, 8'h7A};
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.FSM_Adr = 8'h00;
    bus.FSM_Data = 8'h00;
    repeat (3) @(negedge clk);
    #1 chk_all_zero("reset");
    #1 reset = 1'b0;
    mon_en = 1'b1;

    // Directed single write, then each char-class boundary value.
    dir_adr_q.push_back(8'h05); dir_dat_q.push_back(8'h68);
    burst(1, 1'b1); drain();
    for (int i = 0; i < 6; i++) begin
      dir_adr_q.push_back(8'($urandom)); dir_dat_q.push_back(bnd[i]);
      burst(1, 1'b1); drain();
    end

    // start held through four transactions at addresses 0..3.
    for (int i = 0; i < 4; i++) begin
      dir_adr_q.push_back(8'(i)); dir_dat_q.push_back(8'($urandom));
    end
    burst(4, 1'b1); drain();

    // Enough random traffic to wrap the write counter.
    while (model_cnt < 250) begin
      burst($urandom_range(1, 30), 1'b1); drain();
    end
    burst(12, 1'b1); drain();

    // Reset while the write enable is high: abort with no finish pulse.
    burst(1, 1'b0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 chk_all_zero("abort");
    wr_q.delete(); fin_q.delete();
    held_adr = 8'h00; held_dat = 8'h00;
    model_cnt = 0; model_verr = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    burst(1, 1'b1); drain();
    burst(3, 1'b1); drain();

    // Corrupted read-back, then clean writes: error flag must stay set.
    corrupt = 1'b1;
    burst(2, 1'b1); drain();
    corrupt = 1'b0;
    burst(2, 1'b1); drain();

    chk("wr_queue_empty", wr_q.size(), 32'd0);
    chk("fin_queue_empty", fin_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

endmodule
